nn_weight_loader: RTL

Streaming weight loader that accepts packed weight packets on an AXI-Stream slave and converts them into the layer-aware weight-memory write port (`w_wr_en`/`w_addr_l`/`w_addr_h`/`w_addr_i`/`w_data`) of the bit-serial NN engine. It generates addresses in a fixed order, interlocks against the engine's `busy`, validates packet length, and reports completion and errors to the host controller. It sits between the host DMA and the engine top.

---
 rtl/nn_wload_pkg.sv | 29 ++
 rtl/nn_wload_addr_gen.sv | 55 +++++
 rtl/nn_weight_loader.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/nn_wload_pkg.sv
// Shared types and helpers for the NN weight loader.
package nn_wload_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_FINISH
  } wload_state_e;

  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_N_IN     = 128;
  localparam int unsigned DEF_N_HIDDEN = 64;
  localparam int unsigned DEF_N_LAYERS = 3;

  // Address width with the same single-entry guard the engine uses.
  function automatic int unsigned addr_w(input int unsigned n);
    return $clog2((n > 1) ? n : 2);
  endfunction

  // Number of weight beats in a packet (checksum word excluded).
  function automatic int unsigned expected_beats(input logic load_all,
                                                 input int unsigned n_in,
                                                 input int unsigned n_hidden,
                                                 input int unsigned n_layers);
    return load_all ? n_in * n_hidden * n_layers : n_in * n_hidden;
  endfunction

endpackage

// File: rtl/nn_wload_addr_gen.sv
// Nested i/h/l weight address counter; at_end flags the last weight of the load.
module nn_wload_addr_gen
  import nn_wload_pkg::*;
#(
  parameter int unsigned N_IN     = DEF_N_IN,
  parameter int unsigned N_HIDDEN = DEF_N_HIDDEN,
  parameter int unsigned N_LAYERS = DEF_N_LAYERS,
  parameter int unsigned LW       = addr_w(N_LAYERS),
  parameter int unsigned HW       = addr_w(N_HIDDEN),
  parameter int unsigned IW       = addr_w(N_IN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          load_all,
  input  logic [LW-1:0] load_layer,
  input  logic          advance,
  output logic [LW-1:0] cnt_l,
  output logic [HW-1:0] cnt_h,
  output logic [IW-1:0] cnt_i,
  output logic          at_end
);

  logic [LW-1:0] end_l;

  assign at_end = (cnt_l == end_l) && (cnt_h == HW'(N_HIDDEN - 1)) &&
                  (cnt_i == IW'(N_IN - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_l <= '0;
      cnt_h <= '0;
      cnt_i <= '0;
      end_l <= '0;
    end else if (load) begin
      cnt_l <= load_all ? '0 : load_layer;
      end_l <= load_all ? LW'(N_LAYERS - 1) : load_layer;
      cnt_h <= '0;
      cnt_i <= '0;
    end else if (advance) begin
      if (cnt_i == IW'(N_IN - 1)) begin
        cnt_i <= '0;
        if (cnt_h == HW'(N_HIDDEN - 1)) begin
          cnt_h <= '0;
          cnt_l <= (cnt_l == LW'(N_LAYERS - 1)) ? '0 : cnt_l + 1'b1;
        end else begin
          cnt_h <= cnt_h + 1'b1;
        end
      end else begin
        cnt_i <= cnt_i + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nn_weight_loader.sv
// AXI-Stream weight packet loader feeding the NN engine weight-memory write port.
// Optional trailing checksum word enabled by NN_WLOAD_CHECKSUM_EN.
module nn_weight_loader
  import nn_wload_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned N_IN     = DEF_N_IN,
  parameter int unsigned N_HIDDEN = DEF_N_HIDDEN,
  parameter int unsigned N_LAYERS = DEF_N_LAYERS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_start,
  input  logic                          load_all,
  input  logic [addr_w(N_LAYERS)-1:0]   load_layer,
  input  logic                          engine_busy,
  input  logic [DATA_W-1:0]             s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic                          w_wr_en,
  output logic [addr_w(N_LAYERS)-1:0]   w_addr_l,
  output logic [addr_w(N_HIDDEN)-1:0]   w_addr_h,
  output logic [addr_w(N_IN)-1:0]       w_addr_i,
  output logic [DATA_W-1:0]             w_data,
  output logic                          loader_busy,
  output logic                          done,
  output logic                          err_short,
  output logic                          err_long,
  output logic                          err_csum
);

  localparam int unsigned LW = addr_w(N_LAYERS);
  localparam int unsigned HW = addr_w(N_HIDDEN);
  localparam int unsigned IW = addr_w(N_IN);

  wload_state_e  state;
  logic [LW-1:0] cnt_l;
  logic [HW-1:0] cnt_h;
  logic [IW-1:0] cnt_i;
  logic          at_end;
  logic          start;
  logic          beat;
  logic          wr_beat;

  assign start         = (state == ST_IDLE) && load_start;
  assign s_axis_tready = ((state == ST_LOAD) && !engine_busy) || (state == ST_DRAIN);
  assign beat          = s_axis_tvalid && s_axis_tready;

`ifdef NN_WLOAD_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
  logic              wts_done;
  logic              err_csum_q;
  assign err_csum = err_csum_q;
  // Once all weights are in, the next LOAD beat is the checksum word.
  assign wr_beat  = beat && (state == ST_LOAD) && !wts_done;
`else
  assign err_csum = 1'b0;
  assign wr_beat  = beat && (state == ST_LOAD);
`endif

  nn_wload_addr_gen #(
    .N_IN     (N_IN),
    .N_HIDDEN (N_HIDDEN),
    .N_LAYERS (N_LAYERS),
    .LW       (LW),
    .HW       (HW),
    .IW       (IW)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (start),
    .load_all   (load_all),
    .load_layer (load_layer),
    .advance    (wr_beat),
    .cnt_l      (cnt_l),
    .cnt_h      (cnt_h),
    .cnt_i      (cnt_i),
    .at_end     (at_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      w_wr_en     <= 1'b0;
      w_addr_l    <= '0;
      w_addr_h    <= '0;
      w_addr_i    <= '0;
      w_data      <= '0;
      loader_busy <= 1'b0;
      done        <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
`ifdef NN_WLOAD_CHECKSUM_EN
      csum        <= '0;
      wts_done    <= 1'b0;
      err_csum_q  <= 1'b0;
`endif
    end else begin
      w_wr_en <= 1'b0;
      done    <= 1'b0;
      if (wr_beat) begin
        w_wr_en  <= 1'b1;
        w_addr_l <= cnt_l;
        w_addr_h <= cnt_h;
        w_addr_i <= cnt_i;
        w_data   <= s_axis_tdata;
      end
      unique case (state)
        ST_IDLE: begin
          if (load_start) begin
            state       <= ST_LOAD;
            loader_busy <= 1'b1;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
`ifdef NN_WLOAD_CHECKSUM_EN
            csum        <= '0;
            wts_done    <= 1'b0;
            err_csum_q  <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          if (beat) begin
`ifdef NN_WLOAD_CHECKSUM_EN
            if (wts_done) begin
              if (s_axis_tdata != csum) err_csum_q <= 1'b1;
              if (s_axis_tlast) begin
                state <= ST_FINISH;
                done  <= 1'b1;
              end else begin
                err_long <= 1'b1;
                state    <= ST_DRAIN;
              end
            end else begin
              csum <= csum + s_axis_tdata;
              if (s_axis_tlast) begin
                err_short <= 1'b1;
                state     <= ST_FINISH;
                done      <= 1'b1;
              end else if (at_end) begin
                wts_done <= 1'b1;
              end
            end
`else
            if (s_axis_tlast) begin
              if (!at_end) err_short <= 1'b1;
              state <= ST_FINISH;
              done  <= 1'b1;
            end else if (at_end) begin
              err_long <= 1'b1;
              state    <= ST_DRAIN;
            end
`endif
          end
        end
        ST_DRAIN: begin
          if (beat && s_axis_tlast) begin
            state <= ST_FINISH;
            done  <= 1'b1;
          end
        end
        ST_FINISH: begin
          state       <= ST_IDLE;
          loader_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
